// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle_ctrl button controller: mode encodings,
// default parameter values and the debounce counter width helper.
package toggle_pkg;

   localparam int unsigned DEF_N_CH       = 4;
   localparam int unsigned DEF_DEB_CYCLES = 4;

   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_HOLD   = 1'b1
   } mode_e;

   // Wide enough to hold the value DEB_CYCLES itself.
   function automatic int unsigned deb_cnt_width(input int unsigned deb_cycles);
      return $clog2(deb_cycles + 1);
   endfunction

endpackage : toggle_pkg

// File: rtl/toggle_ch.sv
// One button channel: 2-flop synchroniser, counter debounce, rising-edge
// press pulse and toggle/hold enable state.
module toggle_ch
   import toggle_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic mode,
   input  logic clr,
   output logic state,
   output logic press
);

   localparam int unsigned    CW       = deb_cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          deb;
   logic [CW-1:0] cnt;

   logic differ;
   logic accept;
   logic rise;
   logic deb_next;
   logic state_next;

   // Acceptance is decided combinationally so deb, press and state all
   // change on the same edge that completes the stable run.
   always_comb begin
      differ     = sync_q[1] ^ deb;
      accept     = differ && (cnt == CNT_LAST);
      rise       = accept && sync_q[1];
      deb_next   = accept ? sync_q[1] : deb;
      state_next = state;
      if (clr) begin
         state_next = 1'b0;
      end else if (mode_e'(mode) == MODE_HOLD) begin
         state_next = deb_next;
      end else if (rise) begin
         state_next = ~state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         deb    <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
         state  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], in};
         deb    <= deb_next;
         if (!differ || accept) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         press <= rise;
         state <= state_next;
      end
   end

endmodule : toggle_ch

// File: rtl/toggle_ctrl.sv
// Multi-channel debounced toggle/hold button controller; per-channel logic
// lives in toggle_ch, this level only fans out clr and registers any_en.
module toggle_ctrl
   import toggle_pkg::*;
#(
   parameter int unsigned N_CH       = DEF_N_CH,
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] in,
   input  logic [N_CH-1:0] mode,
   input  logic            clr,
   output logic [N_CH-1:0] state,
   output logic [N_CH-1:0] count_en,
   output logic [N_CH-1:0] press,
   output logic            any_en
);

   logic [N_CH-1:0] clr_fan;

   assign clr_fan  = {N_CH{clr}};
   assign count_en = state;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      toggle_ch #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .in    (in[g]),
         .mode  (mode[g]),
         .clr   (clr_fan[g]),
         .state (state[g]),
         .press (press[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_en <= 1'b0;
      end else begin
         any_en <= |state;
      end
   end

endmodule : toggle_ctrl

// File: tb/tb_toggle_ctrl.sv
// Scoreboard bench for toggle_ctrl: a sliding-window reference model queues
// the expected outputs per clock edge, a monitor pops and compares them.
module tb_toggle_ctrl;

   localparam int unsigned N = 4;
   localparam int unsigned D = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] in_r;
   logic [N-1:0] mode_r;
   logic         clr_r;
   logic [N-1:0] state;
   logic [N-1:0] count_en;
   logic [N-1:0] press;
   logic         any_en;

   toggle_ctrl #(
      .N_CH       (N),
      .DEB_CYCLES (D)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in_r),
      .mode     (mode_r),
      .clr      (clr_r),
      .state    (state),
      .count_en (count_en),
      .press    (press),
      .any_en   (any_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [N-1:0] st;
      logic [N-1:0] pr;
      logic         ae;
   } exp_t;

   exp_t         exp_q[$];
   logic [N-1:0] hist[$];
   logic [N-1:0] m_deb;
   logic [N-1:0] m_state;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           press_cnt[N];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (D + 2) hist.push_back('0);
      m_deb   = '0;
      m_state = '0;
   endtask

   // Expected outputs after the coming rising edge. hist[L-1] is the sample
   // taken at this edge; a level is accepted once the D samples taken at
   // edges k-D-1 .. k-2 (two-flop delay) all disagree with the debounced level.
   task automatic model_edge();
      exp_t         e;
      logic [N-1:0] new_deb;
      logic [N-1:0] rise;
      logic         flip;
      if (!rst_n) begin
         model_reset();
         exp_q.push_back('0);
         return;
      end
      hist.push_back(in_r);
      void'(hist.pop_front());
      e.ae = |m_state;
      for (int c = 0; c < N; c++) begin
         flip = 1'b1;
         for (int i = 0; i < D; i++) begin
            if (hist[i][c] == m_deb[c]) flip = 1'b0;
         end
         new_deb[c] = m_deb[c] ^ flip;
         rise[c]    = flip & new_deb[c];
         if (clr_r)          m_state[c] = 1'b0;
         else if (mode_r[c]) m_state[c] = new_deb[c];
         else if (rise[c])   m_state[c] = ~m_state[c];
      end
      m_deb = new_deb;
      e.st  = m_state;
      e.pr  = rise;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [N-1:0] i_v, input logic [N-1:0] m_v,
                       input logic c_v, input logic r_v);
      @(negedge clk);
      in_r   = i_v;
      mode_r = m_v;
      clr_r  = c_v;
      rst_n  = r_v;
      model_edge();
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every edge presents a new output word.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         for (int c = 0; c < N; c++) if (press[c] === 1'b1) press_cnt[c]++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_state", state, e.st);
            chk("sb_count_en", count_en, e.st);
            chk("sb_press", press, e.pr);
            chk("sb_any_en", any_en, e.ae);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] cur;
      logic [N-1:0] md;
      logic         b;
      int           base;

      for (int c = 0; c < N; c++) press_cnt[c] = 0;
      in_r   = '0;
      mode_r = '0;
      clr_r  = 1'b0;
      rst_n  = 1'b0;
      model_reset();
      #3;
      chk("reset_state", state, 0);
      chk("reset_press", press, 0);
      chk("reset_any_en", any_en, 0);
      step('0, '0, 1'b0, 1'b0);
      repeat (3) step('0, '0, 1'b0, 1'b1);

      // Clean press on ch0, then a second press.
      for (int n = 1; n <= 20; n++) begin
         step(4'b0001, '0, 1'b0, 1'b1);
         if (n >= 5 && n <= 7) begin
            after_edge();
            if (n == 5) chk("clean_no_early_press", press[0], 0);
            if (n == 6) begin
               chk("clean_press_edge6", press[0], 1);
               chk("clean_state_edge6", state[0], 1);
               chk("clean_any_en_lag", any_en, 0);
            end
            if (n == 7) begin
               chk("clean_press_one_cycle", press[0], 0);
               chk("clean_any_en_edge7", any_en, 1);
            end
         end
      end
      repeat (10) step('0, '0, 1'b0, 1'b1);
      repeat (10) step(4'b0001, '0, 1'b0, 1'b1);
      repeat (10) step('0, '0, 1'b0, 1'b1);
      chk("second_press_state", state[0], 0);
      chk("clean_press_count", press_cnt[0], 2);

      // Bounce on ch1: 3 high, 1 low, 3 high, then a clean 4-cycle run.
      for (int n = 0; n < 17; n++) begin
         b = (n < 7) && (n != 3);
         step({2'b00, b, 1'b0}, '0, 1'b0, 1'b1);
      end
      chk("bounce_no_press", press_cnt[1], 0);
      chk("bounce_state", state[1], 0);
      for (int n = 0; n < 14; n++) begin
         b = (n < 4);
         step({2'b00, b, 1'b0}, '0, 1'b0, 1'b1);
      end
      chk("run4_one_press", press_cnt[1], 1);

      // Hold mode on ch2.
      base = press_cnt[2];
      for (int n = 1; n <= 22; n++) begin
         b = (n <= 10);
         step({1'b0, b, 2'b00}, 4'b0100, 1'b0, 1'b1);
         if (n == 5 || n == 6 || n == 15 || n == 16) begin
            after_edge();
            if (n == 5)  chk("hold_state_edge5", state[2], 0);
            if (n == 6)  chk("hold_state_edge6", state[2], 1);
            if (n == 15) chk("hold_state_pre_fall", state[2], 1);
            if (n == 16) chk("hold_state_fall", state[2], 0);
         end
      end
      chk("hold_one_press", press_cnt[2] - base, 1);

      // clr colliding with an accepted press on ch3.
      for (int n = 1; n <= 16; n++) begin
         step(4'b1000, '0, (n == 6), 1'b1);
         if (n == 6) begin
            after_edge();
            chk("clr_press_still", press[3], 1);
            chk("clr_state_zero", state[3], 0);
         end
      end
      repeat (10) step('0, '0, 1'b0, 1'b1);

      // Reset asserted mid-debounce (counter at 3 after edge 5).
      repeat (5) step(4'b0001, '0, 1'b0, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_state", state, 0);
      chk("midrst_count_en", count_en, 0);
      chk("midrst_press", press, 0);
      chk("midrst_any_en", any_en, 0);
      step(4'b0001, '0, 1'b0, 1'b0);
      for (int n = 1; n <= 10; n++) begin
         step(4'b0001, '0, 1'b0, 1'b1);
         if (n == 5 || n == 6) begin
            after_edge();
            if (n == 5) chk("midrst_no_early", press[0], 0);
            if (n == 6) chk("midrst_press_edge6", press[0], 1);
         end
      end
      step('0, '0, 1'b1, 1'b1);
      repeat (10) step('0, '0, 1'b0, 1'b1);

      // All channels together.
      for (int n = 1; n <= 12; n++) begin
         step(4'b1111, '0, 1'b0, 1'b1);
         if (n == 6 || n == 7) begin
            after_edge();
            if (n == 6) begin
               chk("all_press", press, 4'hF);
               chk("all_state", state, 4'hF);
            end
            if (n == 7) chk("all_press_one_cycle", press, 0);
         end
      end
      repeat (10) step('0, '0, 1'b0, 1'b1);

      // Randomised traffic with bounce, mode flips, clr and resets.
      cur = '0;
      md  = '0;
      for (int n = 0; n < 500; n++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 4) == 0)  cur[c] = ~cur[c];
            if ($urandom_range(0, 39) == 0) md[c]  = ~md[c];
         end
         step(cur, md, ($urandom_range(0, 24) == 0), ($urandom_range(0, 149) != 0));
      end

      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_toggle_ctrl
